game_status_ctrl: RTL and testbench

//  Consumer end of the ball/brick engine's event interface. Takes the bottom-hit pulse and the
//  140-bit destroyed-brick flag vector, keeps lives, score and cleared-brick count, and drives

---
 rtl/game_pkg.sv | 47 ++++
 rtl/bcd_counter3.sv | 35 +++
 rtl/game_status_ctrl.sv | 147 ++++++++++++++
 tb/tb_game_status_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the game status controller: FSM states, BCD score types
// and the saturating 3-digit BCD increment.
package game_pkg;

   localparam int unsigned NUM_BRICKS_DEF  = 140;
   localparam int unsigned LIVES_INIT_DEF  = 3;
   localparam int unsigned HOLDOFF_CYC_DEF = 1024;
   localparam int unsigned LIVES_W         = 2;
   localparam int unsigned SCORE_W         = 12;
   localparam int unsigned CLEARED_W       = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      LOST = 2'd2,
      WON  = 2'd3
   } game_state_e;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t hundreds;
      bcd_digit_t tens;
      bcd_digit_t ones;
   } bcd3_t;

   // Decimal +1 with carry ripple; 999 is sticky.
   function automatic bcd3_t bcd3_inc(input bcd3_t v);
      bcd3_t r;
      r = v;
      if ({v.hundreds, v.tens, v.ones} != 12'h999) begin
         if (v.ones != 4'd9) begin
            r.ones = v.ones + 4'd1;
         end else begin
            r.ones = 4'd0;
            if (v.tens != 4'd9) begin
               r.tens = v.tens + 4'd1;
            end else begin
               r.tens     = 4'd0;
               r.hundreds = v.hundreds + 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD counter with synchronous clear and increment, saturating at 999.
// The value is held in a register, so an increment shows one cycle after it is requested.
module bcd_counter3
   import game_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr_i,
   input  logic  inc_i,
   output bcd3_t value_o
);

   bcd3_t value_q;
   bcd3_t value_d;

   always_comb begin
      value_d = value_q;
      if (clr_i) begin
         value_d = '0;
      end else if (inc_i) begin
         value_d = bcd3_inc(value_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value_o = value_q;

endmodule

// File: rtl/game_status_ctrl.sv
// Game status controller: tracks lives, score and cleared bricks from the ball engine's
// bottom-hit pulse and destroyed-brick flags, and drives GameOver/Win back out.
module game_status_ctrl
   import game_pkg::*;
#(
   parameter int unsigned NUM_BRICKS  = NUM_BRICKS_DEF,
   parameter int unsigned LIVES_INIT  = LIVES_INIT_DEF,
   parameter int unsigned HOLDOFF_CYC = HOLDOFF_CYC_DEF
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iClear,
   input  logic                  iRun,
   input  logic                  iScore_En,
   input  logic                  iBottom_Hit,
   input  logic [NUM_BRICKS-1:0] iFlag,
   output logic                  oGameOver,
   output logic                  oWin,
   output logic [LIVES_W-1:0]    oLives,
   output logic [SCORE_W-1:0]    oScore,
   output logic [CLEARED_W-1:0]  oCleared
);

   localparam int unsigned IDX_W = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
   localparam int unsigned HO_W  = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

   game_state_e           state_q,    state_d;
   logic [LIVES_W-1:0]    lives_q,    lives_d;
   logic [CLEARED_W-1:0]  cleared_q,  cleared_d;
   logic [NUM_BRICKS-1:0] shadow_q,   shadow_d;
   logic [IDX_W-1:0]      idx_q,      idx_d;
   logic [HO_W-1:0]       holdoff_q,  holdoff_d;
   logic                  hit_q,      hit_d;
   logic                  gameover_q, gameover_d;
   logic                  win_q,      win_d;

   logic  playing_c;
   logic  hit_rise_c;
   logic  lose_life_c;
   logic  absorb_c;
   logic  score_inc_c;
   bcd3_t score_bcd;

   // Event qualification: counting only happens while the game is live.
   always_comb begin
      playing_c   = (state_q == PLAY) && iRun;
      hit_rise_c  = iBottom_Hit && !hit_q;
      lose_life_c = playing_c && hit_rise_c && (holdoff_q == '0) && (lives_q != '0);
      absorb_c    = playing_c && iFlag[idx_q] && !shadow_q[idx_q];
      score_inc_c = absorb_c && iScore_En && !iClear;
   end

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      cleared_d  = cleared_q;
      shadow_d   = shadow_q;
      hit_d      = iBottom_Hit;
      idx_d      = (idx_q == IDX_W'(NUM_BRICKS - 1)) ? '0 : idx_q + IDX_W'(1);
      holdoff_d  = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : '0;
      gameover_d = gameover_q;
      win_d      = win_q;

      if (lose_life_c) begin
         lives_d   = lives_q - LIVES_W'(1);
         holdoff_d = HO_W'(HOLDOFF_CYC - 1);
      end

      if (absorb_c) begin
         shadow_d[idx_q] = 1'b1;
         cleared_d       = cleared_q + CLEARED_W'(1);
      end

      // A board cleared on the same edge as the last life wins.
      case (state_q)
         IDLE: begin
            if (iRun) begin
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (cleared_d == CLEARED_W'(NUM_BRICKS)) begin
               state_d = WON;
            end else if (lives_d == '0) begin
               state_d = LOST;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      gameover_d = (state_d == LOST);
      win_d      = (state_d == WON);

      if (iClear) begin
         state_d    = IDLE;
         lives_d    = LIVES_W'(LIVES_INIT);
         cleared_d  = '0;
         shadow_d   = '0;
         hit_d      = 1'b0;
         idx_d      = '0;
         holdoff_d  = '0;
         gameover_d = 1'b0;
         win_d      = 1'b0;
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= IDLE;
         lives_q    <= LIVES_W'(LIVES_INIT);
         cleared_q  <= '0;
         shadow_q   <= '0;
         hit_q      <= 1'b0;
         idx_q      <= '0;
         holdoff_q  <= '0;
         gameover_q <= 1'b0;
         win_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         cleared_q  <= cleared_d;
         shadow_q   <= shadow_d;
         hit_q      <= hit_d;
         idx_q      <= idx_d;
         holdoff_q  <= holdoff_d;
         gameover_q <= gameover_d;
         win_q      <= win_d;
      end
   end

   bcd_counter3 u_score (
      .clk     (iCLK),
      .rst_n   (iRST_N),
      .clr_i   (iClear),
      .inc_i   (score_inc_c),
      .value_o (score_bcd)
   );

   assign oGameOver = gameover_q;
   assign oWin      = win_q;
   assign oLives    = lives_q;
   assign oScore    = score_bcd;
   assign oCleared  = cleared_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl plus a standalone bcd_counter3 for carry/saturation.
module tb_game_status_ctrl;
   import game_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         clear = 1'b0;
   logic         run = 1'b0;
   logic         score_en = 1'b0;
   logic         bottom_hit = 1'b0;
   logic [139:0] flag = '0;
   logic         game_over, win;
   logic [1:0]   lives;
   logic [11:0]  score;
   logic [7:0]   cleared;

   logic         bcd_clr = 1'b0;
   logic         bcd_inc = 1'b0;
   bcd3_t        bcd_val;

   always #5 clk = ~clk;

   game_status_ctrl dut (
      .iCLK        (clk),
      .iRST_N      (rst_n),
      .iClear      (clear),
      .iRun        (run),
      .iScore_En   (score_en),
      .iBottom_Hit (bottom_hit),
      .iFlag       (flag),
      .oGameOver   (game_over),
      .oWin        (win),
      .oLives      (lives),
      .oScore      (score),
      .oCleared    (cleared)
   );

   bcd_counter3 u_bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (bcd_clr),
      .inc_i   (bcd_inc),
      .value_o (bcd_val)
   );

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } sb_t;

   sb_t         sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          exp_cleared = 0;
   int          exp_score = 0;

   localparam int S_LIVES = 0, S_SCORE = 1, S_CLEARED = 2, S_OVER = 3, S_WIN = 4, S_BCD = 5;

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_LIVES:   return 32'(lives);
         S_SCORE:   return 32'(score);
         S_CLEARED: return 32'(cleared);
         S_OVER:    return 32'(game_over);
         S_WIN:     return 32'(win);
         default:   return 32'(bcd_val);
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic check_all();
      sb_t         e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.exp)
         else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      cyc += n;
   endtask

   task automatic set_flags(input int lo, input int hi, input bit scored);
      for (int i = lo; i <= hi; i++) begin
         if (!flag[i]) begin
            flag[i] = 1'b1;
            exp_cleared++;
            if (scored && exp_score < 999) exp_score++;
         end
      end
   endtask

   task automatic push_model(input string tag);
      push({tag, "_cleared"}, S_CLEARED, 32'(exp_cleared));
      push({tag, "_score"},   S_SCORE,   32'(to_bcd(exp_score)));
   endtask

   task automatic push_reset_vals(input string tag);
      push({tag, "_lives"},   S_LIVES,   32'd3);
      push({tag, "_score"},   S_SCORE,   32'h000);
      push({tag, "_cleared"}, S_CLEARED, 32'd0);
      push({tag, "_over"},    S_OVER,    32'd0);
      push({tag, "_win"},     S_WIN,     32'd0);
   endtask

   initial begin
      // Reset state
      step(3);
      rst_n = 1'b1;
      push_reset_vals("reset");
      step(1);
      check_all();

      // Standalone BCD counter: carries and saturation
      bcd_inc = 1'b1;
      step(99);
      push("bcd_099", S_BCD, 32'h099);
      check_all();
      step(1);
      push("bcd_carry_100", S_BCD, 32'h100);
      check_all();
      step(898);
      push("bcd_998", S_BCD, 32'h998);
      check_all();
      step(3);
      push("bcd_sat_999", S_BCD, 32'h999);
      check_all();
      bcd_inc = 1'b0;
      bcd_clr = 1'b1;
      step(1);
      bcd_clr = 1'b0;
      push("bcd_clr", S_BCD, 32'h000);
      check_all();

      // Enter PLAY
      run      = 1'b1;
      score_en = 1'b1;
      step(1);
      push("play_lives", S_LIVES, 32'd3);
      push("play_score", S_SCORE, 32'h000);
      push("play_over",  S_OVER,  32'd0);
      check_all();

      // Long bottom hit counts once
      bottom_hit = 1'b1;
      step(1);
      push("hit1_latency", S_LIVES, 32'd2);
      check_all();
      step(6);
      bottom_hit = 1'b0;
      step(1);
      push("hit1_once", S_LIVES, 32'd2);
      check_all();

      // Second pulse inside holdoff window is ignored
      step(492);
      bottom_hit = 1'b1;
      step(7);
      bottom_hit = 1'b0;
      step(1);
      push("hit2_holdoff", S_LIVES, 32'd2);
      check_all();

      // Third pulse after holdoff expires
      step(592);
      bottom_hit = 1'b1;
      step(7);
      bottom_hit = 1'b0;
      step(1);
      push("hit3_dec", S_LIVES, 32'd1);
      check_all();

      // Three bricks including both ends of the vector
      set_flags(0, 0, 1'b1);
      set_flags(77, 77, 1'b1);
      set_flags(139, 139, 1'b1);
      step(141);
      push_model("three_bricks");
      push("three_bricks_bcd", S_SCORE, 32'h003);
      check_all();
      step(1000);
      push_model("held_flags");
      check_all();

      // Unscored absorption
      score_en = 1'b0;
      set_flags(1, 33, 1'b0);
      step(141);
      push_model("unscored");
      check_all();
      score_en = 1'b1;
      set_flags(34, 36, 1'b1);
      step(141);
      push_model("rescored");
      check_all();

      // Last life lost
      bottom_hit = 1'b1;
      step(1);
      bottom_hit = 1'b0;
      push("lost_lives", S_LIVES, 32'd0);
      push("lost_over",  S_OVER,  32'd1);
      push("lost_win",   S_WIN,   32'd0);
      check_all();

      // Terminal LOST ignores hits and flags
      for (int i = 40; i <= 60; i++) flag[i] = 1'b1;
      step(1100);
      bottom_hit = 1'b1;
      step(3);
      bottom_hit = 1'b0;
      step(200);
      push("lost_frozen_lives", S_LIVES, 32'd0);
      push("lost_frozen_over",  S_OVER,  32'd1);
      push_model("lost_frozen");
      check_all();

      // Synchronous clear
      clear = 1'b1;
      flag  = '0;
      step(1);
      clear = 1'b0;
      cyc   = 0;
      exp_cleared = 0;
      exp_score   = 0;
      push_reset_vals("clear");
      check_all();

      // Win with last-life hit in the final absorb cycle
      step(2);
      bottom_hit = 1'b1;
      step(2);
      bottom_hit = 1'b0;
      push("win_prep_l2", S_LIVES, 32'd2);
      check_all();
      step(1030);
      bottom_hit = 1'b1;
      step(2);
      bottom_hit = 1'b0;
      push("win_prep_l1", S_LIVES, 32'd1);
      check_all();
      step(1030);
      set_flags(0, 49, 1'b1);
      set_flags(51, 139, 1'b1);
      step(141);
      push_model("win_139");
      push("win_139_state", S_WIN, 32'd0);
      check_all();
      step(int'((50 + 140 - (cyc % 140)) % 140));
      set_flags(50, 50, 1'b1);
      bottom_hit = 1'b1;
      step(1);
      bottom_hit = 1'b0;
      push("win_flag",    S_WIN,     32'd1);
      push("win_over",    S_OVER,    32'd0);
      push("win_lives",   S_LIVES,   32'd0);
      push("win_cleared", S_CLEARED, 32'd140);
      push("win_score",   S_SCORE,   32'h140);
      check_all();

      // IDLE with run low counts nothing, then a partial board
      run   = 1'b0;
      clear = 1'b1;
      flag  = '0;
      step(1);
      clear = 1'b0;
      exp_cleared = 0;
      exp_score   = 0;
      for (int i = 0; i <= 9; i++) flag[i] = 1'b1;
      step(150);
      push("idle_no_absorb", S_CLEARED, 32'd0);
      check_all();
      run = 1'b1;
      exp_cleared = 10;
      exp_score   = 10;
      step(150);
      push_model("partial");
      check_all();

      // Asynchronous reset between clock edges
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      push_reset_vals("async_rst");
      check_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
